rv32i_trace_buf: RTL and testbench

RV32I_TRACE_BUF -- requirements
Module: rv32i_trace_buf

---
 rtl/rv32i_trace_buf.sv | 145 ++++++++++++++
 tb/tb_rv32i_trace_buf.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rv32i_trace_buf.sv
// rv32i_trace_buf: capture buffer for core commit samples with timestamps.
// Each entry holds {timestamp, sample}. The output is show-ahead, and readout
// works in every state. Define TRACE_PC_TRIGGER_EN to hold capture in ARMED
// until channel 0 matches trig_pc. When it is undefined, arm starts capture
// directly.
module rv32i_trace_buf #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TS_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        arm,
    input  logic                        stop,
    input  logic                        smp_valid,
    input  logic [NUM_CH*XLEN-1:0]      smp_data,
    input  logic [XLEN-1:0]             trig_pc,
    input  logic                        rd_ready,
    output logic                        rd_valid,
    output logic [NUM_CH*XLEN+TS_W-1:0] rd_data,
    output logic [1:0]                  state_o,
    output logic [$clog2(DEPTH):0]      level,
    output logic [15:0]                 drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = NUM_CH * XLEN;
    localparam int unsigned EW = SW + TS_W;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StArmed   = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [AW:0]     count_q;
    logic [TS_W-1:0] ts_q;
    logic [15:0]     drop_q;
    logic [EW-1:0]   mem [DEPTH];

    logic trig_hit;
    logic sample_en;
    logic ts_adv;
    logic flush;
    logic full;
    logic do_pop;
    logic do_write;
    logic do_drop;

`ifdef TRACE_PC_TRIGGER_EN
    localparam state_e ArmTarget = StArmed;
    assign trig_hit = smp_valid && (smp_data[XLEN-1:0] == trig_pc);
`else
    localparam state_e ArmTarget = StCapture;
    logic unused_trig_pc;
    assign unused_trig_pc = ^trig_pc;
    assign trig_hit = 1'b0;
`endif

    // arm only acts outside a session; it flushes the buffer and starts a new session
    assign flush = arm && ((state_q == StIdle) || (state_q == StDone));

    // Next-state logic and per-cycle capture qualification
    always_comb begin
        state_d   = state_q;
        sample_en = 1'b0;
        ts_adv    = 1'b0;
        case (state_q)
            StIdle: begin
                if (arm) state_d = ArmTarget;
            end
            StArmed: begin
                // The triggering sample is the first entry, stamped 0
                if (trig_hit) begin
                    sample_en = 1'b1;
                    ts_adv    = 1'b1;
                    state_d   = StCapture;
                end
                if (stop) state_d = StDone;
            end
            StCapture: begin
                sample_en = smp_valid;
                ts_adv    = 1'b1;
                if (stop) state_d = StDone;
            end
            StDone: begin
                if (arm) state_d = ArmTarget;
            end
            default: state_d = StIdle;
        endcase
    end

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign rd_valid = (count_q != '0);
    assign do_pop   = rd_valid && rd_ready;
    // A full buffer still takes a write when the head leaves on the same edge
    assign do_write = sample_en && (!full || do_pop);
    assign do_drop  = sample_en && full && !do_pop;

    // Control state: FSM, pointers, level, timestamp and drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ts_q    <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
                ts_q    <= '0;
                drop_q  <= '0;
            end else begin
                if (do_write) wptr_q <= wptr_q + AW'(1);
                if (do_pop) rptr_q <= rptr_q + AW'(1);
                case ({do_write, do_pop})
                    2'b10:   count_q <= count_q + (AW+1)'(1);
                    2'b01:   count_q <= count_q - (AW+1)'(1);
                    default: count_q <= count_q;
                endcase
                if (ts_adv) ts_q <= ts_q + TS_W'(1);
                if (do_drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
            end
        end
    end

    // Entry storage; it is not reset because the level gates every read
    always_ff @(posedge clk) begin
        if (do_write) mem[wptr_q] <= {ts_q, smp_data};
    end

    assign rd_data  = rd_valid ? mem[rptr_q] : '0;
    assign state_o  = state_q;
    assign level    = count_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_rv32i_trace_buf.sv
// Bench for rv32i_trace_buf with DEPTH=4. A table of per-cycle vectors drives
// the design, and a scoreboard queue holds the expected entries. Runs with or
// without TRACE_PC_TRIGGER_EN.
module tb_rv32i_trace_buf;

    localparam int XLEN = 32;
    localparam int NCH  = 4;
    localparam int DEP  = 4;
    localparam int TSW  = 16;
    localparam int EW   = NCH*XLEN + TSW;

`ifdef TRACE_PC_TRIGGER_EN
    localparam logic [1:0] SA = 2'd1;
`else
    localparam logic [1:0] SA = 2'd2;
`endif

    logic            clk = 1'b0;
    logic            reset, arm, stop, smp_valid, rd_ready;
    logic [127:0]    smp_data;
    logic [31:0]     trig_pc;
    logic            rd_valid;
    logic [EW-1:0]   rd_data;
    logic [1:0]      state_o;
    logic [2:0]      level;
    logic [15:0]     drop_cnt;

    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] sb[$];

    typedef struct {
        logic        arm, stop, valid;
        logic [31:0] pc;
        logic        rdy, push;
        logic [15:0] ts;
        logic        flush;
        logic [1:0]  st;
        logic [2:0]  lvl;
        logic [15:0] drop;
        logic        rv;
    } vec_t;

    vec_t tbl[19];

    rv32i_trace_buf #(.XLEN(XLEN), .NUM_CH(NCH), .DEPTH(DEP), .TS_W(TSW)) dut (
        .clk      (clk),
        .reset    (reset),
        .arm      (arm),
        .stop     (stop),
        .smp_valid(smp_valid),
        .smp_data (smp_data),
        .trig_pc  (trig_pc),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .state_o  (state_o),
        .level    (level),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] mk(input logic [31:0] pc);
        return {pc ^ 32'hA5A5_0000, pc + 32'h1000_0000, ~pc, pc};
    endfunction

    task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive, check any pop before the edge, check status after it
    task automatic apply(input string tag, input vec_t v);
        logic [EW-1:0] e;
        @(negedge clk);
        arm       = v.arm;
        stop      = v.stop;
        smp_valid = v.valid;
        smp_data  = mk(v.pc);
        rd_ready  = v.rdy;
        if (v.flush) sb.delete();
        if (v.push) sb.push_back({v.ts, mk(v.pc)});
        #1;
        if (rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                chk({tag, "_pop_unexpected"}, {143'd0, rd_valid}, '0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_rd_data"}, rd_data, e);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_state"}, {142'd0, state_o}, {142'd0, v.st});
        chk({tag, "_level"}, {141'd0, level}, {141'd0, v.lvl});
        chk({tag, "_drop"}, {128'd0, drop_cnt}, {128'd0, v.drop});
        chk({tag, "_rd_valid"}, {143'd0, rd_valid}, {143'd0, v.rv});
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; stop = 1'b0; smp_valid = 1'b0;
        rd_ready = 1'b0; smp_data = '0; trig_pc = 32'h8;

        //          arm stop val pc      rdy psh ts   fl st  lvl drop rv
        tbl[0]  = '{1, 0, 0, 32'h00, 0, 0, 16'd0, 1, SA,   3'd0, 16'd0, 0};
        tbl[1]  = '{0, 0, 1, 32'h08, 0, 1, 16'd0, 0, 2'd2, 3'd1, 16'd0, 1};
        tbl[2]  = '{0, 0, 1, 32'h0C, 0, 1, 16'd1, 0, 2'd2, 3'd2, 16'd0, 1};
        tbl[3]  = '{0, 0, 1, 32'h10, 0, 1, 16'd2, 0, 2'd2, 3'd3, 16'd0, 1};
        tbl[4]  = '{0, 0, 1, 32'h14, 0, 1, 16'd3, 0, 2'd2, 3'd4, 16'd0, 1};
        tbl[5]  = '{0, 0, 1, 32'h18, 0, 0, 16'd0, 0, 2'd2, 3'd4, 16'd1, 1};
        tbl[6]  = '{0, 0, 1, 32'h1C, 0, 0, 16'd0, 0, 2'd2, 3'd4, 16'd2, 1};
        tbl[7]  = '{0, 0, 1, 32'h20, 1, 1, 16'd6, 0, 2'd2, 3'd4, 16'd2, 1};
        tbl[8]  = '{0, 0, 0, 32'h00, 1, 0, 16'd0, 0, 2'd2, 3'd3, 16'd2, 1};
        tbl[9]  = '{0, 0, 0, 32'h00, 1, 0, 16'd0, 0, 2'd2, 3'd2, 16'd2, 1};
        tbl[10] = '{0, 1, 1, 32'h24, 1, 1, 16'd9, 0, 2'd3, 3'd2, 16'd2, 1};
        tbl[11] = '{0, 0, 0, 32'h00, 1, 0, 16'd0, 0, 2'd3, 3'd1, 16'd2, 1};
        tbl[12] = '{0, 0, 0, 32'h00, 1, 0, 16'd0, 0, 2'd3, 3'd0, 16'd2, 0};
        tbl[13] = '{0, 0, 1, 32'h28, 1, 0, 16'd0, 0, 2'd3, 3'd0, 16'd2, 0};
        tbl[14] = '{1, 1, 0, 32'h00, 0, 0, 16'd0, 1, SA,   3'd0, 16'd0, 0};
        tbl[15] = '{0, 0, 1, 32'h08, 0, 1, 16'd0, 0, 2'd2, 3'd1, 16'd0, 1};
        tbl[16] = '{0, 1, 0, 32'h00, 0, 0, 16'd0, 0, 2'd3, 3'd1, 16'd0, 1};
        tbl[17] = '{1, 0, 0, 32'h00, 0, 0, 16'd0, 1, SA,   3'd0, 16'd0, 0};
        tbl[18] = '{0, 1, 0, 32'h00, 0, 0, 16'd0, 0, 2'd3, 3'd0, 16'd0, 0};

        // Reset state before any clock edge
        #1;
        chk("rst_state", {142'd0, state_o}, '0);
        chk("rst_level", {141'd0, level}, '0);
        chk("rst_rd_valid", {143'd0, rd_valid}, '0);
        chk("rst_rd_data", rd_data, '0);
        chk("rst_drop", {128'd0, drop_cnt}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) apply($sformatf("v%0d", i), tbl[i]);

        // Asynchronous reset with three entries held
        apply("r0", '{1, 0, 0, 32'h00, 0, 0, 16'd0, 1, SA,   3'd0, 16'd0, 0});
        apply("r1", '{0, 0, 1, 32'h08, 0, 1, 16'd0, 0, 2'd2, 3'd1, 16'd0, 1});
        apply("r2", '{0, 0, 1, 32'h0C, 0, 1, 16'd1, 0, 2'd2, 3'd2, 16'd0, 1});
        apply("r3", '{0, 0, 1, 32'h10, 0, 1, 16'd2, 0, 2'd2, 3'd3, 16'd0, 1});
        @(negedge clk);
        smp_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("arst_level", {141'd0, level}, '0);
        chk("arst_rd_valid", {143'd0, rd_valid}, '0);
        chk("arst_state", {142'd0, state_o}, '0);
        chk("arst_rd_data", rd_data, '0);
        #1;
        reset = 1'b0;
        sb.delete();

`ifdef TRACE_PC_TRIGGER_EN
        // Samples before the trigger PC are not captured
        apply("t0", '{1, 0, 0, 32'h00, 0, 0, 16'd0, 1, 2'd1, 3'd0, 16'd0, 0});
        apply("t1", '{0, 0, 1, 32'h00, 0, 0, 16'd0, 0, 2'd1, 3'd0, 16'd0, 0});
        apply("t2", '{0, 0, 1, 32'h04, 0, 0, 16'd0, 0, 2'd1, 3'd0, 16'd0, 0});
        apply("t3", '{0, 0, 1, 32'h08, 0, 1, 16'd0, 0, 2'd2, 3'd1, 16'd0, 1});
        apply("t4", '{0, 0, 1, 32'h0C, 0, 1, 16'd1, 0, 2'd2, 3'd2, 16'd0, 1});
        apply("t5", '{0, 1, 0, 32'h00, 1, 0, 16'd0, 0, 2'd3, 3'd1, 16'd0, 1});
        apply("t6", '{0, 0, 0, 32'h00, 1, 0, 16'd0, 0, 2'd3, 3'd0, 16'd0, 0});
`else
        // arm goes straight to capture; trig_pc has no effect
        apply("m0", '{1, 0, 0, 32'h00, 0, 0, 16'd0, 1, 2'd2, 3'd0, 16'd0, 0});
        apply("m1", '{0, 0, 1, 32'h00, 0, 1, 16'd0, 0, 2'd2, 3'd1, 16'd0, 1});
        apply("m2", '{0, 1, 0, 32'h00, 1, 0, 16'd0, 0, 2'd3, 3'd0, 16'd0, 0});
        apply("m3", '{1, 0, 0, 32'h00, 0, 0, 16'd0, 1, 2'd2, 3'd0, 16'd0, 0});
`endif

        chk("sb_drained", sb.size(), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
